ecc_secded_pipe: RTL

ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

---
 rtl/ecc_pkg.sv | 26 ++
 rtl/ecc_secded_enc.sv | 29 ++
 rtl/ecc_secded_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: check-width sizing and codeword position mapping.
package ecc_pkg;

  // Smallest P such that 2^P >= data_width + P + 1.
  function automatic int unsigned calc_chk_width(input int unsigned data_width);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < data_width + p + 1) p++;
    return p;
  endfunction

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position (1-based, non-power-of-two) to data bit index.
  function automatic int unsigned pos_to_idx(input int unsigned pos);
    int unsigned npow;
    npow = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      if ((32'd1 << b) <= pos) npow++;
    end
    return pos - npow - 1;
  endfunction

endpackage

// File: rtl/ecc_secded_enc.sv
// Combinational SECDED check-code generator: Hamming bits plus overall parity.
module ecc_secded_enc
  import ecc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 128,
  localparam int unsigned CHK_WIDTH  = calc_chk_width(DATA_WIDTH),
  localparam int unsigned CODE_WIDTH = CHK_WIDTH + 1
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CODE_WIDTH-1:0] code
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  logic [CHK_WIDTH-1:0] ham;

  // Each set data bit contributes its position number to the Hamming bits.
  always_comb begin
    ham = '0;
    for (int unsigned pos = 1; pos <= DATA_WIDTH + CHK_WIDTH; pos++) begin
      if (!is_pow2(pos) && data[IDX_W'(pos_to_idx(pos))]) begin
        ham = ham ^ CHK_WIDTH'(pos);
      end
    end
  end

  assign code = {(^data) ^ (^ham), ham};

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED checker/corrector with valid/ready flow and error counters.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 128,
  parameter  int unsigned CNT_WIDTH  = 16,
  localparam int unsigned CHK_WIDTH  = calc_chk_width(DATA_WIDTH),
  localparam int unsigned CODE_WIDTH = CHK_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CODE_WIDTH-1:0] in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sec,
  output logic                  out_ded,
  output logic [CNT_WIDTH-1:0]  sec_cnt,
  output logic [CNT_WIDTH-1:0]  ded_cnt,
  input  logic                  cnt_clr
);

  localparam int unsigned LAST_POS = DATA_WIDTH + CHK_WIDTH;

  logic [CODE_WIDTH-1:0] recalc;
  logic [CHK_WIDTH-1:0]  syn;
  logic                  par;
  logic                  advance;
  logic                  out_hs;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CHK_WIDTH-1:0]  s1_syn;
  logic                  s1_par;

  logic [31:0]           syn_pos;
  logic [DATA_WIDTH-1:0] corr_data;
  logic                  corr_sec;
  logic                  corr_ded;

  ecc_secded_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .data (in_data),
    .code (recalc)
  );

  assign syn = recalc[CHK_WIDTH-1:0] ^ in_code[CHK_WIDTH-1:0];
  // Overall parity of in_data and in_code, rebuilt from the encoder's parity
  // output: its Hamming terms cancel against the syndrome reduction.
  assign par = recalc[CHK_WIDTH] ^ in_code[CHK_WIDTH] ^ (^syn);

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign out_hs   = out_valid && out_ready;

  // Stage 1: capture data with its syndrome and overall parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_syn  <= syn;
        s1_par  <= par;
      end
    end
  end

  // Decode syndrome/parity into a corrected word and error flags.
  always_comb begin
    syn_pos   = 32'(s1_syn);
    corr_data = s1_data;
    corr_sec  = 1'b0;
    corr_ded  = 1'b0;
    if (s1_par) begin
      if (syn_pos > LAST_POS) begin
        corr_ded = 1'b1;
      end else begin
        corr_sec = 1'b1;
        if (syn_pos != 0 && !is_pow2(syn_pos)) begin
          corr_data = s1_data ^ (DATA_WIDTH'(1) << pos_to_idx(syn_pos));
        end
      end
    end else if (syn_pos != 0) begin
      corr_ded = 1'b1;
    end
  end

  // Stage 2: registered output word, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sec   <= 1'b0;
      out_ded   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= corr_data;
        out_sec  <= corr_sec;
        out_ded  <= corr_ded;
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (out_hs && out_sec && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_WIDTH'(1);
      if (out_hs && out_ded && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
